mole_scheduler: RTL

Game-round controller that sequences the LFSR random-number block to pick which of the NUM_HOLES moles pops up, and how long it stays up. It requests a number, rejects immediate repeats, and shows the mole. It then judges hit or miss from debounced button pulses, keeps saturating score counters, and inserts a gap before the next mole. It sits between the random block, the button debouncers and the LED/7-seg display logic.

---
 rtl/mole_scheduler.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole round controller.
// Requests a random hole from the LFSR block, rejects repeats/out-of-range
// values (with bounded retries and a timeout fallback), shows the mole,
// judges hit/miss from debounced button pulses, keeps saturating scores
// and inserts a gap between rounds.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   run             : level, game running
//   tick            : one-cycle timebase pulse
//   hit_btn[9:0]    : one-cycle debounced button pulses, bit i = hole i
//   rand_num/valid  : number + one-cycle valid from random block
//   next            : request pulse to random block (high only in REQ)
//   max_num         : constant NUM_HOLES-1 for the random block
//   mole_mask       : one-hot active mole, 0 = none
//   mole_idx        : index of current/last mole
//   hit_pulse       : one cycle on correct hit
//   miss_pulse      : one cycle on timeout
//   hit_count       : saturating hit counter
//   miss_count      : saturating miss counter
//   busy            : high in any state except IDLE
module mole_scheduler #(
   parameter int unsigned NUM_HOLES    = 10,
   parameter int unsigned UP_TICKS     = 50,
   parameter int unsigned GAP_TICKS    = 10,
   parameter int unsigned MAX_RETRY    = 3,
   parameter int unsigned RAND_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       tick,
   input  logic [9:0] hit_btn,
   input  logic [3:0] rand_num,
   input  logic       rand_valid,
   output logic       next,
   output logic [3:0] max_num,
   output logic [9:0] mole_mask,
   output logic [3:0] mole_idx,
   output logic       hit_pulse,
   output logic       miss_pulse,
   output logic [7:0] hit_count,
   output logic [7:0] miss_count,
   output logic       busy
);

   localparam int unsigned TW = 16;
   localparam logic [3:0]    HOLES4    = 4'(NUM_HOLES);
   localparam logic [3:0]    RETRY4    = 4'(MAX_RETRY);
   localparam logic [3:0]    NONE_IDX  = 4'hF;

   typedef enum logic [2:0] {IDLE, REQ, WAIT_RAND, UP, GAP} state_t;

   state_t        state, state_n;
   logic [3:0]    last_idx, last_n;
   logic [3:0]    retry, retry_n;
   logic [TW-1:0] tmo_cnt, tmo_n;
   logic [TW-1:0] up_cnt, up_n;
   logic [TW-1:0] gap_cnt, gap_n;
   logic          next_n, hit_n, miss_n, busy_n;
   logic [9:0]    mask_n;
   logic [3:0]    idx_n;
   logic [7:0]    hc_n, mc_n;

   logic          take;
   logic [3:0]    pick;
   logic [3:0]    fallback;
   logic          reject;

   assign max_num = 4'(NUM_HOLES - 1);

   // Next hole after the last one, wrapping; first round falls back to hole 0.
   always_comb begin
      fallback = 4'(last_idx + 4'd1);
      if (last_idx == NONE_IDX || fallback >= HOLES4)
         fallback = 4'd0;
   end

   assign reject = (rand_num >= HOLES4) || (rand_num == last_idx);

   // Next-state and registered-output logic.
   always_comb begin
      state_n = state;
      last_n  = last_idx;
      retry_n = retry;
      tmo_n   = tmo_cnt;
      up_n    = up_cnt;
      gap_n   = gap_cnt;
      mask_n  = mole_mask;
      idx_n   = mole_idx;
      hit_n   = 1'b0;
      miss_n  = 1'b0;
      hc_n    = hit_count;
      mc_n    = miss_count;
      take    = 1'b0;
      pick    = fallback;

      case (state)
         IDLE: begin
            if (run) begin
               state_n = REQ;
               hc_n    = 8'd0;
               mc_n    = 8'd0;
            end
         end
         REQ: begin
            tmo_n   = TW'(RAND_TIMEOUT);
            state_n = WAIT_RAND;
         end
         WAIT_RAND: begin
            if (rand_valid) begin
               if (!reject) begin
                  take = 1'b1;
                  pick = rand_num;
               end else if (retry < RETRY4) begin
                  retry_n = 4'(retry + 4'd1);
                  state_n = REQ;
               end else begin
                  take = 1'b1;
               end
            end else if (tmo_cnt <= TW'(1)) begin
               take = 1'b1;
            end else begin
               tmo_n = TW'(tmo_cnt - TW'(1));
            end
         end
         UP: begin
            // A hit beats an expiring tick in the same cycle.
            if (hit_btn[mole_idx]) begin
               hit_n   = 1'b1;
               if (hit_count != 8'hFF) hc_n = 8'(hit_count + 8'd1);
               mask_n  = 10'd0;
               gap_n   = TW'(GAP_TICKS);
               state_n = GAP;
            end else if (tick) begin
               if (up_cnt <= TW'(1)) begin
                  miss_n  = 1'b1;
                  if (miss_count != 8'hFF) mc_n = 8'(miss_count + 8'd1);
                  mask_n  = 10'd0;
                  gap_n   = TW'(GAP_TICKS);
                  state_n = GAP;
               end else begin
                  up_n = TW'(up_cnt - TW'(1));
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (gap_cnt <= TW'(1)) state_n = REQ;
               else                   gap_n   = TW'(gap_cnt - TW'(1));
            end
         end
         default: state_n = IDLE;
      endcase

      if (take) begin
         idx_n   = pick;
         last_n  = pick;
         mask_n  = 10'(10'd1 << pick);
         up_n    = TW'(UP_TICKS);
         retry_n = 4'd0;
         state_n = UP;
      end

      // Dropping run aborts the round silently; scores and history hold.
      if (state != IDLE && !run) begin
         state_n = IDLE;
         mask_n  = 10'd0;
         idx_n   = mole_idx;
         last_n  = last_idx;
         hit_n   = 1'b0;
         miss_n  = 1'b0;
         hc_n    = hit_count;
         mc_n    = miss_count;
         retry_n = 4'd0;
      end

      next_n = (state_n == REQ);
      busy_n = (state_n != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_idx   <= NONE_IDX;
         retry      <= 4'd0;
         tmo_cnt    <= '0;
         up_cnt     <= '0;
         gap_cnt    <= '0;
         next       <= 1'b0;
         mole_mask  <= 10'd0;
         mole_idx   <= 4'd0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         hit_count  <= 8'd0;
         miss_count <= 8'd0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         last_idx   <= last_n;
         retry      <= retry_n;
         tmo_cnt    <= tmo_n;
         up_cnt     <= up_n;
         gap_cnt    <= gap_n;
         next       <= next_n;
         mole_mask  <= mask_n;
         mole_idx   <= idx_n;
         hit_pulse  <= hit_n;
         miss_pulse <= miss_n;
         hit_count  <= hc_n;
         miss_count <= mc_n;
         busy       <= busy_n;
      end
   end

endmodule
